count_monitor: RTL and testbench

Downstream observer for the 4-bit free-running `counter` stage. It samples the counter value every clock, classifies each transition (step, wrap, clear, illegal jump, threshold match), and keeps a modulo wrap count. Notable transitions are queued as events in a small FIFO and drained over a valid/ready interface by the status/logging logic.

---
 rtl/count_monitor.sv | 166 ++++++++++++++++
 tb/tb_count_monitor.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/count_monitor.sv
// count_monitor: observes the 4-bit free-running counter and classifies each transition.
// The classes are step, wrap, clear, jump and threshold match. It keeps a modulo wrap
// count and queues notable transitions in a small FWFT event FIFO (valid/ready drain).
module count_monitor #(
    parameter int unsigned WRAP_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        q_in,
    input  logic [3:0]        thresh,
    input  logic              clr,
    input  logic              evt_ready,
    output logic              evt_valid,
    output logic [1:0]        evt_code,
    output logic [3:0]        evt_q,
    output logic [WRAP_W-1:0] evt_wraps,
    output logic              match,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic              err_sticky,
    output logic              ovf_sticky
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FullCnt = CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] EvtMatch = 2'd0;
    localparam logic [1:0] EvtWrap  = 2'd1;
    localparam logic [1:0] EvtClear = 2'd2;
    localparam logic [1:0] EvtJump  = 2'd3;

    // Previous sample tracking
    logic [3:0] prev_q;
    logic       prev_vld;

    // Transition classification
    logic [3:0] diff;
    logic       is_wrap;
    logic       is_clear;
    logic       is_jump;
    logic       is_match;

    // Event generation and status next-state
    logic              push;
    logic [1:0]        push_code;
    logic [WRAP_W-1:0] wrap_inc;
    logic [WRAP_W-1:0] wrap_cnt_d;
    logic              err_d;
    logic              ovf_d;

    // FIFO storage and control
    logic [1:0]        code_mem  [FIFO_DEPTH];
    logic [3:0]        q_mem     [FIFO_DEPTH];
    logic [WRAP_W-1:0] wraps_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  fifo_cnt;
    logic [CNT_W-1:0]  fifo_cnt_d;
    logic              fifo_empty;
    logic              fifo_full;
    logic              pop;
    logic              push_ok;
    logic              drop;

    // Classify the transition from prev_q to q_in; nothing fires on the load-only edge
    always_comb begin
        diff     = q_in - prev_q;
        is_wrap  = 1'b0;
        is_clear = 1'b0;
        is_jump  = 1'b0;
        is_match = 1'b0;
        if (prev_vld) begin
            is_wrap  = (diff == 4'd1) && (prev_q == 4'hF);
            is_clear = (q_in == 4'd0) && (diff > 4'd1);
            is_jump  = (q_in != 4'd0) && (diff > 4'd1);
            is_match = (q_in == thresh) && (diff != 4'd0);
        end
    end

    // Pick one event by priority and compute status next-state (clr overrides updates)
    always_comb begin
        push      = is_jump | is_clear | is_wrap | is_match;
        push_code = EvtMatch;
        if (is_jump) begin
            push_code = EvtJump;
        end else if (is_clear) begin
            push_code = EvtClear;
        end else if (is_wrap) begin
            push_code = EvtWrap;
        end
        wrap_inc   = is_wrap ? (wrap_cnt + WRAP_W'(1)) : wrap_cnt;
        wrap_cnt_d = clr ? '0 : wrap_inc;
        err_d      = ~clr & (err_sticky | is_jump);
        ovf_d      = ~clr & (ovf_sticky | drop);
    end

    // FIFO control: a pop frees the slot so a push into a full FIFO is still accepted
    always_comb begin
        fifo_empty = (fifo_cnt == '0);
        fifo_full  = (fifo_cnt == FullCnt);
        pop        = ~fifo_empty & evt_ready;
        push_ok    = push & (~fifo_full | pop);
        drop       = push & fifo_full & ~pop;
        fifo_cnt_d = fifo_cnt;
        if (push_ok && !pop) begin
            fifo_cnt_d = fifo_cnt + CNT_W'(1);
        end else if (!push_ok && pop) begin
            fifo_cnt_d = fifo_cnt - CNT_W'(1);
        end
    end

    // First-word-fall-through head; zero when empty
    always_comb begin
        evt_valid = ~fifo_empty;
        evt_code  = fifo_empty ? 2'd0 : code_mem[rd_ptr];
        evt_q     = fifo_empty ? 4'd0 : q_mem[rd_ptr];
        evt_wraps = fifo_empty ? '0   : wraps_mem[rd_ptr];
    end

    // Sample tracking and status registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_q     <= 4'd0;
            prev_vld   <= 1'b0;
            match      <= 1'b0;
            wrap_cnt   <= '0;
            err_sticky <= 1'b0;
            ovf_sticky <= 1'b0;
        end else begin
            prev_q     <= q_in;
            prev_vld   <= 1'b1;
            match      <= is_match;
            wrap_cnt   <= wrap_cnt_d;
            err_sticky <= err_d;
            ovf_sticky <= ovf_d;
        end
    end

    // FIFO pointers, occupancy and storage
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                code_mem[i]  <= 2'd0;
                q_mem[i]     <= 4'd0;
                wraps_mem[i] <= '0;
            end
        end else begin
            fifo_cnt <= fifo_cnt_d;
            if (push_ok) begin
                code_mem[wr_ptr]  <= push_code;
                q_mem[wr_ptr]     <= q_in;
                // Unclipped value: a coincident clr zeroes wrap_cnt but not the record
                wraps_mem[wr_ptr] <= wrap_inc;
                wr_ptr            <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_count_monitor.sv
// tb_count_monitor: table-driven vectors for classification plus hand-written sequences for
// FIFO overflow, simultaneous push/pop when full, and asynchronous reset mid-stream.
module tb_count_monitor;

    logic       clk;
    logic       reset;
    logic [3:0] q_in;
    logic [3:0] thresh;
    logic       clr;
    logic       evt_ready;
    logic       evt_valid;
    logic [1:0] evt_code;
    logic [3:0] evt_q;
    logic [7:0] evt_wraps;
    logic       match;
    logic [7:0] wrap_cnt;
    logic       err_sticky;
    logic       ovf_sticky;

    int n_cmp = 0;
    int n_bad = 0;

    count_monitor #(
        .WRAP_W     (8),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .q_in       (q_in),
        .thresh     (thresh),
        .clr        (clr),
        .evt_ready  (evt_ready),
        .evt_valid  (evt_valid),
        .evt_code   (evt_code),
        .evt_q      (evt_q),
        .evt_wraps  (evt_wraps),
        .match      (match),
        .wrap_cnt   (wrap_cnt),
        .err_sticky (err_sticky),
        .ovf_sticky (ovf_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  q;
        logic [3:0]  th;
        logic        clr;
        logic        rdy;
        logic [25:0] exp;
    } vec_t;

    vec_t vecs[$];

    // {valid, code, q, wraps, match, wrap_cnt, err, ovf}
    function automatic logic [25:0] pk(logic v, logic [1:0] c, logic [3:0] q, logic [7:0] w,
                                       logic m, logic [7:0] wc, logic e, logic o);
        return {v, c, q, w, m, wc, e, o};
    endfunction

    function automatic logic [25:0] obs();
        return {evt_valid, evt_code, evt_q, evt_wraps, match, wrap_cnt, err_sticky, ovf_sticky};
    endfunction

    task automatic check(input string name, input logic [25:0] act, input logic [25:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h (v,c,q,w,m,wc,e,o) expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] q, input logic [3:0] th, input logic c, input logic r,
                       input logic [25:0] exp);
        vec_t v;
        v.q   = q;
        v.th  = th;
        v.clr = c;
        v.rdy = r;
        v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Synchronous-looking reset pulse; release happens away from the clock edge
    task automatic do_reset();
        reset     = 1'b0;
        q_in      = 4'd0;
        thresh    = 4'd14;
        clr       = 1'b0;
        evt_ready = 1'b0;
        tick();
        check("reset_hold", obs(), '0);
        reset = 1'b1;
    endtask

    logic [3:0] heads[4];

    initial begin
        reset     = 1'b0;
        q_in      = 4'd0;
        thresh    = 4'd5;
        clr       = 1'b0;
        evt_ready = 1'b1;
        #3;
        check("reset_state", obs(), '0);
        #9;
        reset = 1'b1;

        // Phase A: full count 0..15 then wrap, thresh 5
        add(4'd0, 4'd5, 1'b0, 1'b1, '0);
        for (int k = 1; k < 16; k++) begin
            add(4'(k), 4'd5, 1'b0, 1'b1, (k == 5) ? pk(1, 0, 5, 0, 1, 0, 0, 0) : '0);
        end
        add(4'd0, 4'd5, 1'b0, 1'b1, pk(1, 1, 0, 1, 0, 1, 0, 0));   // wrap
        add(4'd1, 4'd5, 1'b0, 1'b1, pk(0, 0, 0, 0, 0, 1, 0, 0));
        add(4'd2, 4'd5, 1'b0, 1'b1, pk(0, 0, 0, 0, 0, 1, 0, 0));
        add(4'd3, 4'd5, 1'b0, 1'b1, pk(0, 0, 0, 0, 0, 1, 0, 0));
        add(4'd9, 4'd5, 1'b0, 1'b1, pk(1, 3, 9, 1, 0, 1, 1, 0));   // jump
        add(4'd9, 4'd5, 1'b0, 1'b1, pk(0, 0, 0, 0, 0, 1, 1, 0));   // hold
        add(4'd9, 4'd5, 1'b1, 1'b1, pk(0, 0, 0, 0, 0, 0, 0, 0));   // clr
        add(4'd7, 4'd5, 1'b0, 1'b1, pk(1, 3, 7, 0, 0, 0, 1, 0));   // jump 9->7
        add(4'd7, 4'd5, 1'b1, 1'b1, pk(0, 0, 0, 0, 0, 0, 0, 0));   // clr
        add(4'd0, 4'd0, 1'b0, 1'b1, pk(1, 2, 0, 0, 1, 0, 0, 0));   // clear 7->0, match suppressed
        add(4'd15, 4'd0, 1'b0, 1'b1, pk(1, 3, 15, 0, 0, 0, 1, 0)); // jump 0->15
        add(4'd0, 4'd0, 1'b1, 1'b1, pk(1, 1, 0, 1, 1, 0, 0, 0));   // wrap + clr: unclipped wraps
        add(4'd1, 4'd0, 1'b0, 1'b1, '0);
        add(4'd0, 4'd0, 1'b0, 1'b1, pk(1, 2, 0, 0, 1, 0, 0, 0));   // 1->0 d=15 is clear
        add(4'd5, 4'd0, 1'b1, 1'b1, pk(1, 3, 5, 0, 0, 0, 0, 0));   // jump + clr: err stays 0
        add(4'd5, 4'd0, 1'b0, 1'b1, '0);

        foreach (vecs[i]) begin
            q_in      = vecs[i].q;
            thresh    = vecs[i].th;
            clr       = vecs[i].clr;
            evt_ready = vecs[i].rdy;
            tick();
            check($sformatf("vec%0d", i), obs(), vecs[i].exp);
        end
        clr = 1'b0;

        // Overflow: five jumps with evt_ready low
        do_reset();
        tick();
        check("ovf_load", obs(), '0);
        heads[0] = 4'd5; heads[1] = 4'd10; heads[2] = 4'd15; heads[3] = 4'd4;
        for (int k = 0; k < 4; k++) begin
            q_in = heads[k];
            tick();
            check($sformatf("ovf_fill%0d", k), obs(), pk(1, 3, 5, 0, 0, 0, 1, 0));
        end
        q_in = 4'd9;
        tick();
        check("ovf_drop", obs(), pk(1, 3, 5, 0, 0, 0, 1, 1));
        evt_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("ovf_drain%0d", k), obs(), pk(1, 3, heads[k], 0, 0, 0, 1, 1));
            tick();
        end
        check("ovf_empty", obs(), pk(0, 0, 0, 0, 0, 0, 1, 1));

        // Full FIFO with simultaneous push and pop
        do_reset();
        tick();
        for (int k = 0; k < 4; k++) begin
            q_in = heads[k];
            tick();
        end
        check("pp_full", obs(), pk(1, 3, 5, 0, 0, 0, 1, 0));
        q_in      = 4'd9;
        evt_ready = 1'b1;
        tick();
        check("pp_same", obs(), pk(1, 3, 10, 0, 0, 0, 1, 0));
        evt_ready = 1'b0;
        tick();
        check("pp_stable", obs(), pk(1, 3, 10, 0, 0, 0, 1, 0));
        heads[0] = 4'd10; heads[1] = 4'd15; heads[2] = 4'd4; heads[3] = 4'd9;
        evt_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("pp_drain%0d", k), obs(), pk(1, 3, heads[k], 0, 0, 0, 1, 0));
            tick();
        end
        check("pp_empty", obs(), pk(0, 0, 0, 0, 0, 0, 1, 0));

        // Asynchronous reset mid-stream with two events queued
        do_reset();
        tick();
        q_in = 4'd5;
        tick();
        q_in = 4'd10;
        tick();
        check("ar_queued", obs(), pk(1, 3, 5, 0, 0, 0, 1, 0));
        #2;
        reset = 1'b0;
        #1;
        check("ar_async", obs(), '0);
        #1;
        reset     = 1'b1;
        q_in      = 4'd7;
        evt_ready = 1'b1;
        tick();
        check("ar_load", obs(), '0);
        q_in = 4'd8;
        tick();
        check("ar_step", obs(), '0);
        q_in = 4'd13;
        tick();
        check("ar_jump", obs(), pk(1, 3, 13, 0, 0, 0, 1, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
